tl_d_grant_unit: RTL and testbench

- Downstream consumer of the L1 D-channel. Accepts Grant/GrantData/ReleaseAck/AccessAck(Data) beats and counts beats of multi-beat messages.
- Streams data beats to the cache refill write port and reports message completion to the MSHR.
- Issues the E-channel GrantAck, carrying the sink of the received Grant, for every Grant/GrantData.
- Sits between the TileLink D/E ports and the L1 MSHR/data array.

---
 rtl/tl_d_grant_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_tl_d_grant_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_d_grant_unit.sv
// TileLink D-channel sink for the L1: counts beats, streams refill data,
// reports Grant/AccessAck/ReleaseAck completion and issues the E-channel GrantAck.
module tl_d_grant_unit #(
  parameter int unsigned DATA_BITS   = 128,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned SOURCE_BITS = 4,
  parameter int unsigned SINK_BITS   = 3,
  parameter int unsigned SIZE_BITS   = 4,
  parameter int unsigned PARAM_BITS  = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   d_valid,
  output logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [PARAM_BITS-1:0]  d_param,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic [SINK_BITS-1:0]   d_sink,
  input  logic                   d_denied,
  input  logic                   d_corrupt,
  input  logic [DATA_BITS-1:0]   d_data,
  output logic                   refill_valid,
  input  logic                   refill_ready,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] refill_beat,
  output logic [SOURCE_BITS-1:0] refill_source,
  output logic [DATA_BITS-1:0]   refill_data,
  output logic                   grant_done,
  output logic [PARAM_BITS-1:0]  grant_param,
  output logic                   grant_denied,
  output logic                   grant_corrupt,
  output logic                   resp_done,
  output logic                   release_ack,
  output logic [SOURCE_BITS-1:0] done_source,
  output logic                   e_valid,
  input  logic                   e_ready,
  output logic [SINK_BITS-1:0]   e_sink
);

  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LOG2_BYTES = $clog2(DATA_BITS / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_ACK   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      cnt_q, cnt_d;
  logic [BEAT_W-1:0]      last_q, last_d;
  logic [2:0]             opcode_q, opcode_d;
  logic [SOURCE_BITS-1:0] source_q, source_d;
  logic                   den_q, den_d;
  logic                   cor_q, cor_d;
  logic                   grant_done_q, grant_done_d;
  logic [PARAM_BITS-1:0]  grant_param_q, grant_param_d;
  logic                   grant_denied_q, grant_denied_d;
  logic                   grant_corrupt_q, grant_corrupt_d;
  logic                   resp_done_q, resp_done_d;
  logic                   release_ack_q, release_ack_d;
  logic [SOURCE_BITS-1:0] done_source_q, done_source_d;
  logic                   e_valid_q, e_valid_d;
  logic [SINK_BITS-1:0]   e_sink_q, e_sink_d;

  logic                   has_data_c;
  logic                   first_c;
  logic [2:0]             opcode_c;
  logic [SOURCE_BITS-1:0] source_c;
  logic                   needs_ack_c;
  logic                   is_resp_c;
  logic                   is_release_c;
  logic [31:0]            bytes_c;
  logic [31:0]            beats_c;
  logic [BEAT_W-1:0]      last_calc_c;
  logic [BEAT_W-1:0]      last_idx_c;
  logic                   d_hs_c;
  logic                   last_beat_c;
  logic                   den_c;
  logic                   cor_c;

  // Message decode; the first beat is taken live, later beats use the latched header
  always_comb begin
    has_data_c   = d_opcode[0];
    first_c      = (state_q == S_IDLE);
    opcode_c     = first_c ? d_opcode : opcode_q;
    source_c     = first_c ? d_source : source_q;
    needs_ack_c  = opcode_c[2] & ~opcode_c[1];
    is_resp_c    = (opcode_c[2:1] == 2'b00);
    is_release_c = (opcode_c == 3'd6);
    den_c        = (~first_c & den_q) | d_denied;
    cor_c        = (~first_c & cor_q) | d_corrupt;
  end

  // Beats in this message as a last-beat index, clamped to [1, BEATS] beats
  always_comb begin
    bytes_c = 32'd1 << d_size;
    beats_c = bytes_c >> LOG2_BYTES;
    if (!has_data_c || (beats_c == 32'd0)) begin
      beats_c = 32'd1;
    end else if (beats_c > 32'(BEATS)) begin
      beats_c = 32'(BEATS);
    end
    last_calc_c = BEAT_W'(beats_c - 32'd1);
    last_idx_c  = first_c ? last_calc_c : last_q;
  end

  // D handshake and refill pass-through
  always_comb begin
    d_ready       = (state_q != S_ACK) & (~has_data_c | refill_ready);
    refill_valid  = d_valid & has_data_c & (state_q != S_ACK);
    refill_beat   = cnt_q;
    refill_source = d_source;
    refill_data   = d_data;
    d_hs_c        = d_valid & d_ready;
    last_beat_c   = d_hs_c & (cnt_q == last_idx_c);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (last_beat_c) begin
          state_d = needs_ack_c ? S_ACK : S_IDLE;
        end else if (d_hs_c) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (last_beat_c) begin
          state_d = needs_ack_c ? S_ACK : S_IDLE;
        end
      end
      S_ACK: begin
        if (e_valid_q && e_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat counting, header latching, completion pulses and GrantAck generation
  always_comb begin
    cnt_d           = cnt_q;
    last_d          = last_q;
    opcode_d        = opcode_q;
    source_d        = source_q;
    den_d           = den_q;
    cor_d           = cor_q;
    grant_done_d    = 1'b0;
    resp_done_d     = 1'b0;
    release_ack_d   = 1'b0;
    grant_param_d   = grant_param_q;
    grant_denied_d  = grant_denied_q;
    grant_corrupt_d = grant_corrupt_q;
    done_source_d   = done_source_q;
    e_valid_d       = e_valid_q;
    e_sink_d        = e_sink_q;

    if (d_hs_c) begin
      cnt_d = last_beat_c ? '0 : cnt_q + BEAT_W'(1);
      den_d = den_c;
      cor_d = cor_c;
      if (first_c) begin
        opcode_d = d_opcode;
        source_d = d_source;
        last_d   = last_calc_c;
      end
    end

    if (last_beat_c) begin
      done_source_d = source_c;
      if (needs_ack_c) begin
        grant_done_d    = 1'b1;
        grant_param_d   = d_param;
        grant_denied_d  = den_c;
        grant_corrupt_d = cor_c;
        e_valid_d       = 1'b1;
        e_sink_d        = d_sink;
      end else if (is_resp_c) begin
        resp_done_d = 1'b1;
      end else if (is_release_c) begin
        release_ack_d = 1'b1;
      end
    end

    if ((state_q == S_ACK) && e_valid_q && e_ready) begin
      e_valid_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      last_q          <= '0;
      opcode_q        <= '0;
      source_q        <= '0;
      den_q           <= 1'b0;
      cor_q           <= 1'b0;
      grant_done_q    <= 1'b0;
      grant_param_q   <= '0;
      grant_denied_q  <= 1'b0;
      grant_corrupt_q <= 1'b0;
      resp_done_q     <= 1'b0;
      release_ack_q   <= 1'b0;
      done_source_q   <= '0;
      e_valid_q       <= 1'b0;
      e_sink_q        <= '0;
    end else begin
      cnt_q           <= cnt_d;
      last_q          <= last_d;
      opcode_q        <= opcode_d;
      source_q        <= source_d;
      den_q           <= den_d;
      cor_q           <= cor_d;
      grant_done_q    <= grant_done_d;
      grant_param_q   <= grant_param_d;
      grant_denied_q  <= grant_denied_d;
      grant_corrupt_q <= grant_corrupt_d;
      resp_done_q     <= resp_done_d;
      release_ack_q   <= release_ack_d;
      done_source_q   <= done_source_d;
      e_valid_q       <= e_valid_d;
      e_sink_q        <= e_sink_d;
    end
  end

  assign grant_done    = grant_done_q;
  assign grant_param   = grant_param_q;
  assign grant_denied  = grant_denied_q;
  assign grant_corrupt = grant_corrupt_q;
  assign resp_done     = resp_done_q;
  assign release_ack   = release_ack_q;
  assign done_source   = done_source_q;
  assign e_valid       = e_valid_q;
  assign e_sink        = e_sink_q;

  // Opcode and source must not change inside a burst
  a_burst_header_stable: assert property (@(posedge clock) disable iff (!reset_n)
    (state_q == S_BURST && d_valid) |-> (d_opcode == opcode_q && d_source == source_q));

endmodule

// File: tb/tb_tl_d_grant_unit.sv
// Directed bench for tl_d_grant_unit with refill/done/GrantAck scoreboards.
module tb_tl_d_grant_unit;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         d_valid;
  logic         d_ready;
  logic [2:0]   d_opcode;
  logic [1:0]   d_param;
  logic [3:0]   d_size;
  logic [3:0]   d_source;
  logic [2:0]   d_sink;
  logic         d_denied;
  logic         d_corrupt;
  logic [127:0] d_data;
  logic         refill_valid;
  logic         refill_ready;
  logic [1:0]   refill_beat;
  logic [3:0]   refill_source;
  logic [127:0] refill_data;
  logic         grant_done;
  logic [1:0]   grant_param;
  logic         grant_denied;
  logic         grant_corrupt;
  logic         resp_done;
  logic         release_ack;
  logic [3:0]   done_source;
  logic         e_valid;
  logic         e_ready;
  logic [2:0]   e_sink;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]   beat;
    logic [3:0]   src;
    logic [127:0] data;
  } refill_t;

  typedef struct packed {
    logic [1:0] kind;   // 0 grant, 1 access resp, 2 release ack
    logic [3:0] src;
    logic [1:0] param;
    logic       denied;
    logic       corrupt;
  } done_t;

  refill_t    sb_refill[$];
  done_t      sb_done[$];
  logic [2:0] sb_esink[$];

  tl_d_grant_unit dut (
    .clock(clock), .reset_n(reset_n),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_corrupt(d_corrupt), .d_data(d_data),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_beat(refill_beat),
    .refill_source(refill_source), .refill_data(refill_data),
    .grant_done(grant_done), .grant_param(grant_param), .grant_denied(grant_denied),
    .grant_corrupt(grant_corrupt), .resp_done(resp_done), .release_ack(release_ack),
    .done_source(done_source), .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_beats(input logic [2:0] op, input logic [3:0] sz);
    int b;
    if (!op[0]) return 1;
    b = (1 << sz) >> 4;
    if (b < 1) b = 1;
    if (b > 4) b = 4;
    return b;
  endfunction

  // Starts and ends at a negedge; holds the current beat until accepted
  task automatic wait_accept(input bit fast);
    int  n   = 0;
    bit  acc = 1'b0;
    while (!acc && n < 64) begin
      #4;
      acc = d_ready;
      if (acc) chk("refill_valid_on_accept", refill_valid, d_opcode[0]);
      @(negedge clock);
      n++;
    end
    chk("beat_accepted", acc, 1);
    if (fast) chk("beat_accept_cycles", n, 1);
  endtask

  task automatic send_msg(input logic [2:0] op, input logic [1:0] prm, input logic [3:0] sz,
                          input logic [3:0] src, input logic [2:0] snk,
                          input int den_beat, input int cor_beat,
                          input int stall_at, input int stall_len,
                          input int abort_after, input bit fast);
    int   nb;
    logic den, cor;
    done_t ev;
    nb  = model_beats(op, sz);
    den = 1'b0;
    cor = 1'b0;
    for (int i = 0; i < nb && i < abort_after; i++) begin
      d_opcode  = op;
      d_param   = prm;
      d_size    = sz;
      d_source  = src;
      d_sink    = snk;
      d_denied  = (i == den_beat);
      d_corrupt = (i == cor_beat);
      d_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
      den       = den | d_denied;
      cor       = cor | d_corrupt;
      if (op[0]) sb_refill.push_back('{beat: 2'(i), src: src, data: d_data});
      d_valid = 1'b1;
      if (i == stall_at) begin
        refill_ready = 1'b0;
        repeat (stall_len) begin
          #4;
          chk("stall_d_ready", d_ready, 0);
          chk("stall_refill_beat", refill_beat, i);
          @(negedge clock);
        end
        refill_ready = 1'b1;
      end
      wait_accept(fast && (i != stall_at));
    end
    d_valid   = 1'b0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    if (abort_after >= nb) begin
      ev.src     = src;
      ev.param   = prm;
      ev.denied  = den;
      ev.corrupt = cor;
      if (op[2] && !op[1]) begin
        ev.kind = 2'd0;
        sb_esink.push_back(snk);
      end else if (op == 3'd6) begin
        ev.kind = 2'd2;
      end else begin
        ev.kind = 2'd1;
      end
      sb_done.push_back(ev);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_refill.size() + sb_done.size() + sb_esink.size()) != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("scoreboard_drained", sb_refill.size() + sb_done.size() + sb_esink.size(), 0);
  endtask

  // Monitor: samples one time unit before each rising edge
  logic       prev_hs = 1'b0;
  logic       prev_ev = 1'b0;
  logic       prev_er = 1'b0;
  logic [2:0] prev_sink = '0;
  always begin
    refill_t r;
    done_t   ev;
    logic [2:0] s;
    @(negedge clock);
    #4;
    if (!reset_n) begin
      prev_hs = 1'b0;
      prev_ev = 1'b0;
    end else begin
      if (d_valid && d_ready && refill_valid) begin
        if (sb_refill.size() == 0) chk("refill_unexpected", refill_valid, 0);
        else begin
          r = sb_refill.pop_front();
          chk("refill_beat", refill_beat, r.beat);
          chk("refill_source", refill_source, r.src);
          chk("refill_data", refill_data, r.data);
        end
      end
      if (refill_valid && !refill_ready) chk("refill_stall_d_ready", d_ready, 0);
      if (e_valid) chk("ack_state_d_ready", d_ready, 0);
      if (prev_ev && !prev_er) begin
        chk("e_hold_valid", e_valid, 1);
        chk("e_hold_sink", e_sink, prev_sink);
      end
      if (e_valid && e_ready) begin
        if (sb_esink.size() == 0) chk("e_unexpected", e_valid, 0);
        else begin
          s = sb_esink.pop_front();
          chk("e_sink", e_sink, s);
        end
      end
      if (grant_done || resp_done || release_ack) begin
        chk("done_latency", prev_hs, 1);
        chk("done_onehot", $countones({grant_done, resp_done, release_ack}), 1);
        if (sb_done.size() == 0) chk("done_unexpected", {grant_done, resp_done, release_ack}, 0);
        else begin
          ev = sb_done.pop_front();
          chk("done_kind", {release_ack, resp_done, grant_done},
              (ev.kind == 2'd0) ? 3'b001 : (ev.kind == 2'd1) ? 3'b010 : 3'b100);
          chk("done_source", done_source, ev.src);
          if (ev.kind == 2'd0) begin
            chk("grant_param", grant_param, ev.param);
            chk("grant_denied", grant_denied, ev.denied);
            chk("grant_corrupt", grant_corrupt, ev.corrupt);
            chk("grant_e_valid", e_valid, 1);
          end
        end
      end
      prev_hs   = d_valid && d_ready;
      prev_ev   = e_valid;
      prev_er   = e_ready;
      prev_sink = e_sink;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = '0;
    d_source = '0; d_sink = '0; d_denied = 1'b0; d_corrupt = 1'b0; d_data = '0;
    refill_ready = 1'b1; e_ready = 1'b1;
    repeat (3) @(negedge clock);
    #4;
    chk("rst_e_valid", e_valid, 0);
    chk("rst_e_sink", e_sink, 0);
    chk("rst_grant_done", grant_done, 0);
    chk("rst_resp_done", resp_done, 0);
    chk("rst_release_ack", release_ack, 0);
    chk("rst_refill_beat", refill_beat, 0);
    chk("rst_d_ready", d_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // GrantData, 4 beats back to back
    send_msg(3'd5, 2'd1, 4'd6, 4'd1, 3'd3, -1, -1, -1, 0, 99, 1'b1);
    #4;
    chk("t1_grant_done", grant_done, 1);
    chk("t1_e_valid", e_valid, 1);
    chk("t1_e_sink", e_sink, 3);
    chk("t1_d_ready", d_ready, 0);
    @(negedge clock);
    #4;
    chk("t1_e_valid_drop", e_valid, 0);
    chk("t1_grant_done_drop", grant_done, 0);
    @(negedge clock);
    drain();

    // Grant without data
    send_msg(3'd4, 2'd0, 4'd6, 4'd2, 3'd5, -1, -1, -1, 0, 99, 1'b1);
    #4;
    chk("t2_grant_done", grant_done, 1);
    chk("t2_grant_param", grant_param, 0);
    chk("t2_e_valid", e_valid, 1);
    chk("t2_e_sink", e_sink, 5);
    @(negedge clock);
    drain();

    // Access responses: 2-beat data, no data, sub-beat data
    send_msg(3'd1, 2'd0, 4'd5, 4'd9, 3'd0, -1, -1, -1, 0, 99, 1'b1);
    #4;
    chk("t3_resp_done", resp_done, 1);
    chk("t3_e_valid", e_valid, 0);
    @(negedge clock);
    send_msg(3'd0, 2'd0, 4'd3, 4'd10, 3'd0, -1, -1, -1, 0, 99, 1'b1);
    send_msg(3'd1, 2'd0, 4'd2, 4'd11, 3'd0, -1, -1, -1, 0, 99, 1'b1);
    drain();

    // Oversized GrantData clamps to 4 beats; refill stall at beat 2; sticky flags
    send_msg(3'd5, 2'd2, 4'd8, 4'd12, 3'd1, 3, 1, 2, 3, 99, 1'b1);
    drain();

    // GrantAck back-pressure with a ReleaseAck waiting behind it
    e_ready = 1'b0;
    send_msg(3'd5, 2'd1, 4'd6, 4'd2, 3'd6, -1, -1, -1, 0, 99, 1'b1);
    d_opcode = 3'd6; d_source = 4'd4; d_size = 4'd6; d_valid = 1'b1;
    repeat (5) begin
      #4;
      chk("t5_e_valid_hold", e_valid, 1);
      chk("t5_e_sink_hold", e_sink, 6);
      chk("t5_d_ready_low", d_ready, 0);
      @(negedge clock);
    end
    e_ready = 1'b1;
    send_msg(3'd6, 2'd0, 4'd6, 4'd4, 3'd0, -1, -1, -1, 0, 99, 1'b0);
    drain();

    // ReleaseAck
    send_msg(3'd6, 2'd0, 4'd6, 4'd7, 3'd0, -1, -1, -1, 0, 99, 1'b1);
    #4;
    chk("t6_release_ack", release_ack, 1);
    chk("t6_done_source", done_source, 7);
    chk("t6_e_valid", e_valid, 0);
    @(negedge clock);
    #4;
    chk("t6_release_ack_drop", release_ack, 0);
    @(negedge clock);
    drain();

    // Reset after beat 1 of a GrantData, then a clean GrantData
    send_msg(3'd5, 2'd3, 4'd6, 4'd5, 3'd4, 0, 1, -1, 0, 2, 1'b1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #4;
    chk("t7_grant_done", grant_done, 0);
    chk("t7_e_valid", e_valid, 0);
    chk("t7_e_sink", e_sink, 0);
    chk("t7_refill_beat", refill_beat, 0);
    chk("t7_refill_valid", refill_valid, 0);
    chk("t7_grant_denied", grant_denied, 0);
    chk("t7_grant_corrupt", grant_corrupt, 0);
    chk("t7_done_source", done_source, 0);
    @(negedge clock);
    repeat (3) @(negedge clock);
    send_msg(3'd5, 2'd1, 4'd6, 4'd3, 3'd2, -1, -1, -1, 0, 99, 1'b1);
    #4;
    chk("t7_next_grant_done", grant_done, 1);
    chk("t7_next_e_sink", e_sink, 2);
    @(negedge clock);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
